// File: rtl/race_pkg.sv
// Shared encodings and screen geometry for the race game sequencer and its
// sub-blocks.
package race_pkg;

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'b00,
    ST_RUN     = 2'b01,
    ST_CRASH   = 2'b10
  } state_e;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int ROAD_LEFT   = 160;
  localparam int ROAD_RIGHT  = SCREEN_W - 192;
  localparam int CAR_X_START = 304;

  localparam int CAR_X_W  = 10;
  localparam int SCROLL_W = 9;
  localparam int SPEED_W  = 3;
  localparam int SCORE_W  = 16;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, stability counter and rising-edge pulse for one
// raw mechanical button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_db,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_db;
  logic          r_db_d;
  logic [CW-1:0] r_cnt;

  // Any sample equal to the current debounced level restarts the count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_db    <= 1'b0;
      r_db_d  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= i_raw;
      r_sync1 <= r_sync0;
      r_db_d  <= r_db;
      if (r_sync1 != r_db) begin
        if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_db  <= r_sync1;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_db    = r_db;
  assign o_press = r_db & ~r_db_d;

endmodule

// File: rtl/race_game_ctrl.sv
// Race game sequencer: button conditioning, ATTRACT/RUN/CRASH control and the
// once-per-frame update of car position, road scroll, speed and score.
module race_game_ctrl
  import race_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int X_MIN           = ROAD_LEFT,
  parameter int X_MAX           = ROAD_RIGHT,
  parameter int X_START         = CAR_X_START,
  parameter int STEP            = 4,
  parameter int SCROLL_WRAP     = SCREEN_H,
  parameter int SPEEDUP_FRAMES  = 300,
  parameter int MAX_SPEED       = 7,
  parameter int CRASH_FRAMES    = 120
) (
  input  logic                i_clk50mhz,
  input  logic                i_reset,
  input  logic                i_left,
  input  logic                i_right,
  input  logic                i_frame_tick,
  input  logic                i_collision,
  output logic [1:0]          o_game_state,
  output logic [CAR_X_W-1:0]  o_car_x,
  output logic [SCROLL_W-1:0] o_scroll_y,
  output logic [SPEED_W-1:0]  o_speed,
  output logic [SCORE_W-1:0]  o_score
);

  localparam int FC_W = $clog2(SPEEDUP_FRAMES + 1);
  localparam int CC_W = $clog2(CRASH_FRAMES + 1);

  logic w_l_db, w_r_db, w_l_press, w_r_press;

  state_e              r_state;
  logic [CAR_X_W-1:0]  r_car_x;
  logic [SCROLL_W-1:0] r_scroll_y;
  logic [SPEED_W-1:0]  r_speed;
  logic [SCORE_W-1:0]  r_score;
  logic [FC_W-1:0]     r_frame_cnt;
  logic [CC_W-1:0]     r_crash_cnt;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .i_clk(i_clk50mhz), .i_reset(i_reset), .i_raw(i_left),
    .o_db(w_l_db), .o_press(w_l_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .i_clk(i_clk50mhz), .i_reset(i_reset), .i_raw(i_right),
    .o_db(w_r_db), .o_press(w_r_press)
  );

  // Edge clamps use one extra bit so a step past either bound cannot wrap.
  function automatic logic [CAR_X_W-1:0] move_left(input logic [CAR_X_W-1:0] x);
    logic [CAR_X_W:0] w_wide;
    w_wide = {1'b0, x};
    if (w_wide < (CAR_X_W+1)'(X_MIN + STEP)) return CAR_X_W'(X_MIN);
    return CAR_X_W'(w_wide - (CAR_X_W+1)'(STEP));
  endfunction

  function automatic logic [CAR_X_W-1:0] move_right(input logic [CAR_X_W-1:0] x);
    logic [CAR_X_W:0] w_wide;
    w_wide = {1'b0, x} + (CAR_X_W+1)'(STEP);
    if (w_wide > (CAR_X_W+1)'(X_MAX)) return CAR_X_W'(X_MAX);
    return CAR_X_W'(w_wide);
  endfunction

  function automatic logic [SCROLL_W-1:0] wrap_scroll(input logic [SCROLL_W-1:0] s,
                                                      input logic [SPEED_W-1:0]  v);
    logic [SCROLL_W:0] w_sum;
    w_sum = {1'b0, s} + (SCROLL_W+1)'(v);
    if (w_sum >= (SCROLL_W+1)'(SCROLL_WRAP))
      return SCROLL_W'(w_sum - (SCROLL_W+1)'(SCROLL_WRAP));
    return SCROLL_W'(w_sum);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + SCORE_W'(1);
  endfunction

  function automatic logic [SPEED_W-1:0] speed_up(input logic [SPEED_W-1:0] v);
    return (v >= SPEED_W'(MAX_SPEED)) ? v : v + SPEED_W'(1);
  endfunction

  always_ff @(posedge i_clk50mhz) begin
    if (i_reset) begin
      r_state     <= ST_ATTRACT;
      r_car_x     <= CAR_X_W'(X_START);
      r_scroll_y  <= '0;
      r_speed     <= SPEED_W'(1);
      r_score     <= '0;
      r_frame_cnt <= '0;
      r_crash_cnt <= '0;
    end else begin
      case (r_state)
        ST_ATTRACT: begin
          // A press wins over a coincident frame tick: no frame update this cycle.
          if (w_l_press || w_r_press) begin
            r_state     <= ST_RUN;
            r_car_x     <= CAR_X_W'(X_START);
            r_scroll_y  <= '0;
            r_speed     <= SPEED_W'(1);
            r_score     <= '0;
            r_frame_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (i_frame_tick) begin
            if (w_l_db && !w_r_db)      r_car_x <= move_left(r_car_x);
            else if (w_r_db && !w_l_db) r_car_x <= move_right(r_car_x);
            r_scroll_y <= wrap_scroll(r_scroll_y, r_speed);
            r_score    <= sat_inc(r_score);
            if (r_frame_cnt == FC_W'(SPEEDUP_FRAMES - 1)) begin
              r_frame_cnt <= '0;
              r_speed     <= speed_up(r_speed);
            end else begin
              r_frame_cnt <= r_frame_cnt + FC_W'(1);
            end
            if (i_collision) begin
              r_state     <= ST_CRASH;
              r_crash_cnt <= '0;
            end
          end
        end
        ST_CRASH: begin
          if (i_frame_tick) begin
            if (r_crash_cnt == CC_W'(CRASH_FRAMES - 1)) begin
              r_state     <= ST_ATTRACT;
              r_crash_cnt <= '0;
            end else begin
              r_crash_cnt <= r_crash_cnt + CC_W'(1);
            end
          end
        end
        default: r_state <= ST_ATTRACT;
      endcase
    end
  end

  assign o_game_state = r_state;
  assign o_car_x      = r_car_x;
  assign o_scroll_y   = r_scroll_y;
  assign o_speed      = r_speed;
  assign o_score      = r_score;

endmodule
